// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared Mini SRC definitions: opcodes, sequencer state encoding and the
// instruction classes produced by op_decoder.
// Optional feature macro (used by importers): CU_MULDIV_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  // Opcodes held in IR[31:27]; Datapath decodes ALU ops from the same values
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // Sequencer states; T0..T7 are consecutive so a step index maps by offset
  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  // Instruction classes sharing one execute sequence
  typedef enum logic [3:0] {
    CL_ALU    = 4'd0,
    CL_ADDI   = 4'd1,
    CL_LDI    = 4'd2,
    CL_LD     = 4'd3,
    CL_ST     = 4'd4,
    CL_BR     = 4'd5,
    CL_JR     = 4'd6,
    CL_JAL    = 4'd7,
    CL_NOP    = 4'd8,
    CL_HALT   = 4'd9,
    CL_MULDIV = 4'd10,
    CL_MFHI   = 4'd11,
    CL_MFLO   = 4'd12
  } iclass_t;

  // Step index n (0..7) to the matching Tn state
  function automatic state_t step_state(input logic [2:0] n);
    return state_t'({1'b0, n} + 4'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
// Bundle between the control sequencer (master) and Datapath (slave):
// instruction/condition inputs, Run status and every datapath strobe.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface control_unit_if;
  logic [31:0] IR;
  logic CON_FF, Stop, Run;
  logic PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, BAout, InPortout, Rout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, R15in, Rin, CONin;
  logic Gra, Grb, Grc;
  logic IncPC, Read, Write, ADD;

  modport master (
    input  IR, CON_FF, Stop,
    output Run,
    output PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, BAout, InPortout, Rout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, R15in, Rin, CONin,
    output Gra, Grb, Grc,
    output IncPC, Read, Write, ADD
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  Run,
    input  PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, BAout, InPortout, Rout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, R15in, Rin, CONin,
    input  Gra, Grb, Grc,
    input  IncPC, Read, Write, ADD
  );
endinterface

`default_nettype wire

// File: rtl/control_unit_op_decoder.sv
// ---------------------------------------------------------------------------
// op_decoder
// Combinational opcode decode: instruction class and index of the last
// execute step (3..7). Undefined opcodes decode as nop.
// Optional feature macro: CU_MULDIV_EN (mul/div/mfhi/mflo classes)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module op_decoder
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output iclass_t        iclass,
  output logic [2:0]     last_step
);

  // Opcode to class and sequence length
  always_comb begin
    iclass    = CL_NOP;
    last_step = 3'd3;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin iclass = CL_ALU;  last_step = 3'd5; end
      OP_ADDI:                       begin iclass = CL_ADDI; last_step = 3'd5; end
      OP_LDI:                        begin iclass = CL_LDI;  last_step = 3'd5; end
      OP_LD:                         begin iclass = CL_LD;   last_step = 3'd7; end
      OP_ST:                         begin iclass = CL_ST;   last_step = 3'd7; end
      OP_BR:                         begin iclass = CL_BR;   last_step = 3'd6; end
      OP_JR:                         begin iclass = CL_JR;   last_step = 3'd3; end
      OP_JAL:                        begin iclass = CL_JAL;  last_step = 3'd4; end
      OP_HALT:                       begin iclass = CL_HALT; last_step = 3'd3; end
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                begin iclass = CL_MULDIV; last_step = 3'd6; end
      OP_MFHI:                       begin iclass = CL_MFHI;   last_step = 3'd3; end
      OP_MFLO:                       begin iclass = CL_MFLO;   last_step = 3'd3; end
`endif
      default:                       begin iclass = CL_NOP;  last_step = 3'd3; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired Mini SRC sequencer: RESET -> fetch T0..T2 -> execute T3..T7 ->
// fetch, with halt instruction and Stop handling. Strobes are a Moore decode
// of state and latched IR (br's T6 additionally gates on CON_FF).
// Optional feature macro: CU_MULDIV_EN (mul/div/mfhi/mflo sequences)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master bus
);

  state_t     state;
  iclass_t    iclass;
  logic [2:0] last_step;
  logic       at_last;
  logic       unused_ir;

  // Only the opcode field steers sequencing
  assign unused_ir = ^bus.IR[31-OPW:0];

  op_decoder #(.OPW(OPW)) u_op_decoder (
    .opcode    (bus.IR[31:32-OPW]),
    .iclass    (iclass),
    .last_step (last_step)
  );

  assign at_last = (state == step_state(last_step));

  // Step sequencing; Clear wins asynchronously from any state
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= ST_RESET;
    end else begin
      case (state)
        ST_RESET: state <= ST_T0;
        ST_T0:    state <= ST_T1;
        ST_T1:    state <= ST_T2;
        ST_T2:    state <= ST_T3;
        ST_HALT:  state <= ST_HALT;
        default: begin
          if (iclass == CL_HALT)  state <= ST_HALT;
          else if (at_last)       state <= bus.Stop ? ST_HALT : ST_T0;
          else                    state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  // Strobe decode from current step and instruction class
  always_comb begin
    bus.Run = 1'b0;
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhiout = 1'b0; bus.MDRout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.Cout = 1'b0; bus.BAout = 1'b0;
    bus.InPortout = 1'b0; bus.Rout = 1'b0;
    bus.PCin = 1'b0; bus.IRin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0;
    bus.Yin = 1'b0; bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
    bus.R15in = 1'b0; bus.Rin = 1'b0; bus.CONin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0; bus.ADD = 1'b0;

    bus.Run = (state != ST_RESET) && (state != ST_HALT);

    case (state)
      ST_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      ST_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      ST_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        case (iclass)
          CL_ALU: begin
            case (state)
              ST_T3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              ST_T4: begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
              ST_T5: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: ;
            endcase
          end
          CL_ADDI, CL_LDI: begin
            case (state)
              ST_T3: begin
                bus.Grb = 1'b1; bus.Yin = 1'b1;
                if (iclass == CL_LDI) bus.BAout = 1'b1;
                else                  bus.Rout  = 1'b1;
              end
              ST_T4: begin bus.Cout = 1'b1; bus.ADD = 1'b1; bus.Zin = 1'b1; end
              ST_T5: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: ;
            endcase
          end
          CL_LD, CL_ST: begin
            case (state)
              ST_T3: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
              ST_T4: begin bus.Cout = 1'b1; bus.ADD = 1'b1; bus.Zin = 1'b1; end
              ST_T5: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
              ST_T6: begin
                if (iclass == CL_LD) begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                else begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
              end
              ST_T7: begin
                if (iclass == CL_LD) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else bus.Write = 1'b1;
              end
              default: ;
            endcase
          end
          CL_BR: begin
            case (state)
              ST_T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
              ST_T4: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
              ST_T5: begin bus.Cout = 1'b1; bus.ADD = 1'b1; bus.Zin = 1'b1; end
              ST_T6: begin bus.Zlowout = bus.CON_FF; bus.PCin = bus.CON_FF; end
              default: ;
            endcase
          end
          CL_JR: begin
            if (state == ST_T3) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          end
          CL_JAL: begin
            case (state)
              ST_T3: begin bus.PCout = 1'b1; bus.R15in = 1'b1; end
              ST_T4: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
              default: ;
            endcase
          end
`ifdef CU_MULDIV_EN
          CL_MULDIV: begin
            case (state)
              ST_T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              ST_T4: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
              ST_T5: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
              ST_T6: begin bus.Zhiout = 1'b1; bus.HIin = 1'b1; end
              default: ;
            endcase
          end
          CL_MFHI: begin
            if (state == ST_T3) begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          end
          CL_MFLO: begin
            if (state == ST_T3) begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
